// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the sram_nr1w N-read / 1-write SRAM.
//   sram_state_t     : controller state (post-reset clear sweep or serving)
//   RDW_NEW_DATA     : same-address read returns the word being written
//   RDW_OLD_DATA     : same-address read returns the word before the write
//   parity_of()      : even parity of a word of up to PARITY_MAX_WIDTH bits
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    SRAM_CLEAR = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_t;

  // Read-during-write policies, stored as 8-character packed strings so the
  // top-level parameter can be compared without a string type.
  localparam logic [63:0] RDW_NEW_DATA = "NEW_DATA";
  localparam logic [63:0] RDW_OLD_DATA = "OLD_DATA";

  // Callers zero-extend their data to this width; zero padding does not
  // change the parity result.
  localparam int PARITY_MAX_WIDTH = 256;

  function automatic logic parity_of(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_nr1w_array.sv
// -----------------------------------------------------------------------------
// sram_nr1w_array
// Plain reset-less storage for sram_nr1w. All range checking, collision
// handling and clearing is done by the caller; this block only stores words.
//   clk      : clock, all activity on posedge
//   rd_en    : per-port read strobe, loads that port's data register
//   rd_addr  : packed per-port read address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  : packed per-port registered data, port i at [i*WIDTH +: WIDTH]
//   wr_en    : write strobe
//   wr_addr  : write address (caller guarantees it is below SIZE)
//   wr_data  : write word
// -----------------------------------------------------------------------------
module sram_nr1w_array #(
  parameter int WIDTH          = 32,
  parameter int SIZE           = 128,
  parameter int NUM_READ_PORTS = 2,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic                                clk,
  input  logic [NUM_READ_PORTS-1:0]           rd_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*WIDTH-1:0]     rd_data,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [WIDTH-1:0]                    wr_data
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking semantics mean a read on the same edge as a write to the
  // same word captures the pre-write contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (rd_en[i]) begin
        rd_data[i*WIDTH +: WIDTH] <= mem[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: rtl/sram_nr1w.sv
// -----------------------------------------------------------------------------
// sram_nr1w
// Parametrised SRAM with NUM_READ_PORTS read ports and one write port.
// After reset it optionally sweeps zeros through every word before raising
// ready. Reads have one cycle of latency and each port holds its last result
// while idle. Same-address read/write collisions follow READ_DURING_WRITE.
// Addresses at or above SIZE drop writes and read as zero.
//
// Optional feature, enabled by defining SRAM_PARITY_EN: every word carries an
// even-parity bit and read_parity_err flags corrupted stored words.
//
// Ports:
//   clk              : clock
//   reset_n          : asynchronous active-low reset
//   read_en          : per-port read strobe
//   read_addr        : packed per-port read address
//   read_data        : packed per-port registered read data
//   write_en         : write strobe
//   write_addr       : write address
//   write_data       : write data
//   ready            : high once the clear sweep is done; traffic accepted only then
//   read_parity_err  : per-port parity error (SRAM_PARITY_EN only)
// -----------------------------------------------------------------------------
module sram_nr1w
  import sram_pkg::*;
#(
  parameter int          DATA_WIDTH        = 32,
  parameter int          SIZE              = 128,
  parameter int          NUM_READ_PORTS    = 2,
  parameter logic [63:0] READ_DURING_WRITE = "NEW_DATA",
  parameter int          CLEAR_ON_RESET    = 1,
  parameter int          ADDR_WIDTH        = $clog2(SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_READ_PORTS-1:0]            read_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  input  logic                                 write_en,
  input  logic [ADDR_WIDTH-1:0]                write_addr,
  input  logic [DATA_WIDTH-1:0]                write_data,
  output logic                                 ready
`ifdef SRAM_PARITY_EN
  ,
  output logic [NUM_READ_PORTS-1:0]            read_parity_err
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int WORD_WIDTH = DATA_WIDTH + PARITY_BITS;

  localparam logic                  NEW_DATA_MODE = (READ_DURING_WRITE == RDW_NEW_DATA);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   SIZE_LIMIT    = (ADDR_WIDTH + 1)'(SIZE);
  localparam sram_state_t           RESET_STATE   = (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_READY;

  sram_state_t               state;
  sram_state_t               state_next;
  logic [ADDR_WIDTH-1:0]     clear_addr;
  logic                      ready_q;
  logic                      clearing;
  logic                      write_in_range;
  logic                      accept_write;
  logic [WORD_WIDTH-1:0]     write_word;

  logic                      arr_wr_en;
  logic [ADDR_WIDTH-1:0]     arr_wr_addr;
  logic [WORD_WIDTH-1:0]     arr_wr_data;
  logic [NUM_READ_PORTS-1:0] arr_rd_en;
  logic [NUM_READ_PORTS*WORD_WIDTH-1:0] arr_rd_data;

  // State register; reset lands in the clear sweep only when it is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // The sweep ends on the cycle it writes the last word.
  always_comb begin
    state_next = state;
    case (state)
      SRAM_CLEAR: if (clear_addr == LAST_ADDR) state_next = SRAM_READY;
      SRAM_READY: state_next = SRAM_READY;
      default:    state_next = RESET_STATE;
    endcase
  end

  // Sweep address counter and the registered ready flag. ready follows the
  // next state so it rises on the same edge that commits the final clear write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_addr <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (state == SRAM_CLEAR) begin
        clear_addr <= clear_addr + 1'b1;
      end
      ready_q <= (state_next == SRAM_READY);
    end
  end

  assign ready          = ready_q;
  assign clearing       = (state == SRAM_CLEAR);
  assign write_in_range = ({1'b0, write_addr} < SIZE_LIMIT);
  assign accept_write   = ready_q & write_en & write_in_range;

`ifdef SRAM_PARITY_EN
  assign write_word = {parity_of(PARITY_MAX_WIDTH'(write_data)), write_data};
`else
  assign write_word = write_data;
`endif

  // The clear sweep owns the write port; it stores an all-zero word, which
  // also has a consistent parity bit of 0.
  assign arr_wr_en   = clearing | accept_write;
  assign arr_wr_addr = clearing ? clear_addr : write_addr;
  assign arr_wr_data = clearing ? '0 : write_word;

  sram_nr1w_array #(
    .WIDTH          (WORD_WIDTH),
    .SIZE           (SIZE),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (arr_rd_en),
    .rd_addr (read_addr),
    .rd_data (arr_rd_data),
    .wr_en   (arr_wr_en),
    .wr_addr (arr_wr_addr),
    .wr_data (arr_wr_data)
  );

  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] word;
    logic                  accept;
    logic                  in_range;
    logic                  forward;
    logic                  sel_zero_q;
    logic                  sel_fwd_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    assign addr     = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign word     = arr_rd_data[i*WORD_WIDTH +: WORD_WIDTH];
    assign accept   = ready_q & read_en[i];
    assign in_range = ({1'b0, addr} < SIZE_LIMIT);
    // Only an accepted write can collide, so dropped out-of-range writes never forward.
    assign forward  = NEW_DATA_MODE & accept_write & in_range & (addr == write_addr);

    // The array register is loaded only for plain in-range reads, so it keeps
    // its value whenever this port's result comes from elsewhere.
    assign arr_rd_en[i] = accept & in_range & ~forward;

    // Per-port source select and forwarded word. Everything updates only on
    // an accepted read, which is what makes the output hold while idle.
    // Reset selects the zero source because the array register is not reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sel_zero_q <= 1'b1;
        sel_fwd_q  <= 1'b0;
        fwd_data_q <= '0;
      end else if (accept) begin
        sel_zero_q <= ~in_range;
        sel_fwd_q  <= forward;
        if (forward) begin
          fwd_data_q <= write_data;
        end
      end
    end

    assign read_data[i*DATA_WIDTH +: DATA_WIDTH] =
      sel_zero_q ? '0 : (sel_fwd_q ? fwd_data_q : word[DATA_WIDTH-1:0]);

`ifdef SRAM_PARITY_EN
    assign read_parity_err[i] = ~sel_zero_q & ~sel_fwd_q &
      (parity_of(PARITY_MAX_WIDTH'(word[DATA_WIDTH-1:0])) != word[DATA_WIDTH]);
`endif
  end

endmodule

// File: tb/tb_sram_nr1w.sv
// -----------------------------------------------------------------------------
// tb_sram_nr1w
// Two instances share one stimulus stream: one with NEW_DATA and one with
// OLD_DATA collision behaviour, both SIZE=52 with the clear sweep enabled.
// A word-array reference model predicts every read result. Define
// SRAM_PARITY_EN to also exercise the parity error outputs.
// -----------------------------------------------------------------------------
module tb_sram_nr1w;

  localparam int DW   = 32;
  localparam int SIZE = 52;
  localparam int NRP  = 2;
  localparam int AW   = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NRP-1:0]    read_en;
  logic [NRP*AW-1:0] read_addr;
  logic              write_en;
  logic [AW-1:0]     write_addr;
  logic [DW-1:0]     write_data;
  logic [NRP*DW-1:0] rd_new;
  logic [NRP*DW-1:0] rd_old;
  logic              ready_new;
  logic              ready_old;
`ifdef SRAM_PARITY_EN
  logic [NRP-1:0]    perr_new;
  logic [NRP-1:0]    perr_old;
`endif

  always #5 clk = ~clk;

  sram_nr1w #(
    .DATA_WIDTH(DW), .SIZE(SIZE), .NUM_READ_PORTS(NRP),
    .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1)
  ) dut_new (
    .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_new), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .ready(ready_new)
`ifdef SRAM_PARITY_EN
    , .read_parity_err(perr_new)
`endif
  );

  sram_nr1w #(
    .DATA_WIDTH(DW), .SIZE(SIZE), .NUM_READ_PORTS(NRP),
    .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1)
  ) dut_old (
    .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_old), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .ready(ready_old)
`ifdef SRAM_PARITY_EN
    , .read_parity_err(perr_old)
`endif
  );

  // Reference model: plain word array plus the expected held output per port.
  logic [DW-1:0] mem_m   [SIZE];
  logic [DW-1:0] exp_new [NRP];
  logic [DW-1:0] exp_old [NRP];
  bit            model_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] n0;
    logic [DW-1:0] n1;
    logic [DW-1:0] o0;
    logic [DW-1:0] o1;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of traffic (called just after a negedge), advances the
  // model at the posedge and compares every read port at the next negedge.
  task automatic apply_stimulus(input logic [NRP-1:0] re, input logic [AW-1:0] ra0,
                                input logic [AW-1:0] ra1, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [AW-1:0] a;
    read_en    = re;
    read_addr  = {ra1, ra0};
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    @(posedge clk);
    if (model_ready) begin
      for (int i = 0; i < NRP; i++) begin
        if (re[i]) begin
          a = (i == 0) ? ra0 : ra1;
          if (int'(a) >= SIZE) begin
            exp_new[i] = '0;
            exp_old[i] = '0;
          end else if (we && wa == a) begin
            exp_new[i] = wd;
            exp_old[i] = mem_m[a];
          end else begin
            exp_new[i] = mem_m[a];
            exp_old[i] = mem_m[a];
          end
        end
      end
      if (we && int'(wa) < SIZE) mem_m[wa] = wd;
    end
    @(negedge clk);
    for (int i = 0; i < NRP; i++) begin
      check_output($sformatf("new_rd%0d", i), rd_new[i*DW +: DW], exp_new[i]);
      check_output($sformatf("old_rd%0d", i), rd_old[i*DW +: DW], exp_old[i]);
    end
  endtask

  task automatic random_cycle();
    logic [AW-1:0] wa;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    wa  = AW'($urandom_range(0, 63));
    ra0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 63));
    ra1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 63));
    apply_stimulus(NRP'($urandom_range(0, 3)), ra0, ra1,
                   1'($urandom_range(0, 1)), wa, $urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_ready"}, 32'(ready_new), 32'h0);
    check_output({tag, "_rd0"}, rd_new[DW-1:0], 32'h0);
    check_output({tag, "_rd1_old"}, rd_old[2*DW-1:DW], 32'h0);
  endtask

  // Resets, optionally aborts the sweep after abort_at cycles with a second
  // reset, then runs a full sweep with random traffic that must be ignored.
  task automatic reset_and_clear(input int abort_at);
    reset_n     = 1'b0;
    read_en     = '0;
    read_addr   = '0;
    write_en    = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    model_ready = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      exp_new[i] = '0;
      exp_old[i] = '0;
    end
    @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    if (abort_at > 0) begin
      for (int k = 1; k <= abort_at; k++) begin
        random_cycle();
        check_output("abort_ready", 32'(ready_new), 32'h0);
      end
      reset_n = 1'b0;
      #1;
      check_reset_state("midclear");
      @(negedge clk);
      reset_n = 1'b1;
    end
    for (int k = 1; k <= SIZE; k++) begin
      random_cycle();
      check_output($sformatf("clear_ready_new_c%0d", k), 32'(ready_new), 32'(k == SIZE));
      check_output($sformatf("clear_ready_old_c%0d", k), 32'(ready_old), 32'(k == SIZE));
    end
    for (int a = 0; a < SIZE; a++) mem_m[a] = '0;
    model_ready = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 6'd0,  6'd0, 1'b1, 6'd7,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{2'b01, 6'd7,  6'd0, 1'b0, 6'd0,  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{2'b00, 6'd0,  6'd0, 1'b0, 6'd0,  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = vecs[2];
    vecs[6]  = vecs[2];
    vecs[7]  = '{2'b00, 6'd0,  6'd0, 1'b1, 6'd9,  32'h1111, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{2'b11, 6'd9,  6'd9, 1'b1, 6'd9,  32'h2222, 32'h2222, 32'h2222, 32'h1111, 32'h1111};
    vecs[9]  = '{2'b11, 6'd9,  6'd9, 1'b0, 6'd0,  32'h0, 32'h2222, 32'h2222, 32'h2222, 32'h2222};
    vecs[10] = '{2'b11, 6'd60, 6'd7, 1'b1, 6'd60, 32'hFFFF, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[11] = '{2'b11, 6'd60, 6'd9, 1'b0, 6'd0,  32'h0, 32'h0, 32'h2222, 32'h0, 32'h2222};
    vecs[12] = '{2'b11, 6'd51, 6'd0, 1'b0, 6'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[13] = '{2'b10, 6'd0,  6'd7, 1'b1, 6'd7,  32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0, 32'hDEADBEEF};

    $display("[TB] starting");
    reset_and_clear(0);

    for (int v = 0; v < 14; v++) begin
      apply_stimulus(vecs[v].re, vecs[v].ra0, vecs[v].ra1, vecs[v].we, vecs[v].wa, vecs[v].wd);
      check_output($sformatf("vec%0d_new0", v), rd_new[DW-1:0],    vecs[v].n0);
      check_output($sformatf("vec%0d_new1", v), rd_new[2*DW-1:DW], vecs[v].n1);
      check_output($sformatf("vec%0d_old0", v), rd_old[DW-1:0],    vecs[v].o0);
      check_output($sformatf("vec%0d_old1", v), rd_old[2*DW-1:DW], vecs[v].o1);
    end

    for (int n = 0; n < 400; n++) random_cycle();

    // Contents are now arbitrary; a reset aborted mid-sweep must still zero them.
    reset_and_clear(20);
    for (int a = 0; a < SIZE; a++) begin
      apply_stimulus(2'b11, AW'(a), AW'(SIZE - 1 - a), 1'b0, '0, '0);
    end
    check_output("post_clear_rd0_addr51", rd_new[DW-1:0], 32'h0);

`ifdef SRAM_PARITY_EN
    apply_stimulus(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 32'h0000000F);
    dut_new.u_array.mem[3][0] = ~dut_new.u_array.mem[3][0];
    dut_old.u_array.mem[3][0] = ~dut_old.u_array.mem[3][0];
    mem_m[3] = 32'h0000000E;
    apply_stimulus(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0);
    check_output("par_corrupt_data", rd_new[DW-1:0], 32'h0000000E);
    check_output("par_corrupt_err_new", 32'(perr_new[0]), 32'h1);
    check_output("par_corrupt_err_old", 32'(perr_old[0]), 32'h1);
    apply_stimulus(2'b01, 6'd3, 6'd0, 1'b1, 6'd3, 32'h00000055);
    check_output("par_forward_err_new", 32'(perr_new[0]), 32'h0);
    check_output("par_oldread_err_old", 32'(perr_old[0]), 32'h1);
    apply_stimulus(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0);
    check_output("par_rewritten_err_new", 32'(perr_new[0]), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_nr1w.md
Name: sram_nr1w

Overview:
- Parametrised behavioural SRAM with N read ports and 1 write port. Successor to the fixed-geometry fakeram_* wrappers.
- Adds read-during-write forwarding, held read outputs, a post-reset clear sequencer, and out-of-range address protection.
- Drop-in storage for caches, tag arrays and register files in the Nyuzi core. A plain storage array sits underneath the control logic.

Parameters:
- DATA_WIDTH, 32, bits per word.
- SIZE, 128, number of words. Need not be a power of two (e.g. 52).
- NUM_READ_PORTS, 2, number of independent read ports, 1..4.
- READ_DURING_WRITE, "NEW_DATA", same-address collision result: "NEW_DATA" or "OLD_DATA".
- CLEAR_ON_RESET, 1, when 1, zero every word after reset before accepting traffic.
- ADDR_WIDTH, $clog2(SIZE), derived; do not override.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- read_en  in  NUM_READ_PORTS  per-port read strobe.
- read_addr  in  NUM_READ_PORTS*ADDR_WIDTH  packed per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  NUM_READ_PORTS*DATA_WIDTH  packed per-port registered data.
- write_en  in  1  write strobe.
- write_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- ready  out  1  high once the clear sequence is done; writes and reads accepted only while high.
- read_parity_err  out  NUM_READ_PORTS  present only with SRAM_PARITY_EN.

Behaviour:
- Reset (reset_n low, async):
  - read_data=0; ready=0; clear counter=0; forwarding registers=0.
  - Array contents are not reset.
- FSM states CLEAR, READY:
  - After reset release: CLEAR if CLEAR_ON_RESET=1, else READY directly.
  - CLEAR writes 0 to counter address each cycle; counter runs 0..SIZE-1.
  - At SIZE-1, go to READY; ready rises the next cycle. CLEAR therefore lasts exactly SIZE cycles.
  - reset_n asserted mid-clear restarts the sequence at address 0.
- While ready=0:
  - write_en is ignored.
  - read_en is ignored; read_data holds 0.
- Read latency 1:
  - read_en[i] high at edge t → read_data[i] valid after edge t+1.
  - read_data[i] holds its last value while read_en[i] is low.
- Write: write_en high at edge t → the word is updated at edge t and visible to reads issued at t+1.
- Collision (read_en[i] & write_en & equal addresses, same cycle):
  - NEW_DATA: read_data[i] = write_data.
  - OLD_DATA: read_data[i] = pre-write contents.
  - Resolved independently per port. Any number of ports may collide simultaneously.
- Out-of-range address (addr >= SIZE, only possible when SIZE is not a power of two):
  - Write is dropped; array unchanged.
  - Read returns 0.
- Multiple ports reading the same address in the same cycle each return identical data.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Array stores one extra even-parity bit per word (^write_data).
  - On each read, read_parity_err[i] is registered alongside read_data[i]: 1 if the stored parity does not match the stored data.
  - Forwarded (NEW_DATA collision) and out-of-range reads report 0.
  - read_parity_err resets to 0 and holds with read_data.
  - The clear sequence writes parity 0.
- Undefined: no parity storage, no read_parity_err port; array is DATA_WIDTH wide.

Decomposition:
- Package sram_pkg:
  - Typedef sram_state_t {SRAM_CLEAR, SRAM_READY}.
  - Constants RDW_NEW_DATA and RDW_OLD_DATA.
  - Helper function parity_of.
- Sub-module sram_nr1w_array: pure storage, reset-less, with NUM_READ_PORTS combinational-address/registered-data read ports and 1 write port. Width is DATA_WIDTH(+1 with parity).
- Top level holds the FSM, clear counter, collision compare/mux, range checks and output hold.

Test Plan:
- Clear, SIZE=52, CLEAR_ON_RESET=1, arbitrary array preload → ready rises after exactly 52 cycles; reads of addr 0, 25 and 51 return 0. Deassert reset_n at cycle 20, release → clear restarts and needs 52 more cycles.
- Basic latency → write 0xDEADBEEF to addr 7; read port 0 addr 7 the next cycle → data appears 1 cycle after read_en. With read_en low for 5 cycles, read_data stays 0xDEADBEEF.
- NEW_DATA collision: addr 9 holds 0x1111 → write 0x2222 to addr 9 while ports 0 and 1 both read addr 9 → both return 0x2222. Rebuilt with OLD_DATA → both return 0x1111; a read the next cycle returns 0x2222.
- Out-of-range, SIZE=52 → write 0xFFFF to addr 60; read addr 60 returns 0; reads of addr 0..51 unchanged.
- Traffic during clear → write_en and read_en pulsed before ready → no array change; read_data stays 0.
- SRAM_PARITY_EN → write 0x0F to addr 3, then flip stored bit 0 via hierarchical deposit; reading addr 3 gives read_parity_err=1 and data 0x0E. Collision read of the same address gives error 0.
